// File: rtl/cu_responder_if.sv
// Channel-side signal bundle between a channel (master) and a control unit (slave).
// Outbound and inbound buses both carry odd parity.
interface cu_responder_if;
  logic [7:0] bus_out;
  logic       bus_out_parity;
  logic       operational_out;
  logic       select_out;
  logic       hold_out;
  logic       address_out;
  logic       command_out;
  logic       service_out;

  logic [7:0] bus_in;
  logic       bus_in_parity;
  logic       operational_in;
  logic       select_in;
  logic       address_in;
  logic       status_in;
  logic       request_in;

  modport master (
    output bus_out, bus_out_parity, operational_out, select_out, hold_out,
           address_out, command_out, service_out,
    input  bus_in, bus_in_parity, operational_in, select_in, address_in,
           status_in, request_in
  );

  modport slave (
    input  bus_out, bus_out_parity, operational_out, select_out, hold_out,
           address_out, command_out, service_out,
    output bus_in, bus_in_parity, operational_in, select_in, address_in,
           status_in, request_in
  );
endinterface

// File: rtl/cu_responder.sv
// Control-unit responder: answers channel selection at CU_ADDRESS, hands commands to
// local logic, returns a status byte, and disconnects; wait states are timeout-guarded.
module cu_responder #(
  parameter logic [7:0]  CU_ADDRESS     = 8'h50,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             reset,
  cu_responder_if.slave    ch,
  output logic             cmd_valid,
  output logic [7:0]       cmd_byte,
  output logic             cmd_parity_error,
  input  logic [7:0]       status_byte,
  output logic             status_accepted,
  output logic             status_stacked,
  output logic             timeout
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SYN_W = 15;

  typedef enum logic [2:0] {
    IDLE, PROPAGATE, SELECTED, ADDR_IN, CMD_WAIT, STATUS_IN, STATUS_END, DISCONNECT
  } state_e;

  state_e             state_q, next_state;
  logic [SYN_W-1:0]   sync1_q, sync2_q;
  logic [1:0]         warm_q;
  logic               sh_prev_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [7:0] s_bus;
  logic       s_par, s_op, s_sel, s_hold, s_addr, s_cmd, s_svc;
  logic       sh, sh_rise, bus_ok, tmo_c;

  logic [7:0] bus_d, cb_d;
  logic       par_d, op_d, sel_d, addr_d, stat_d, cv_d, pe_d, acc_d, stk_d, tmo_d;

  // Two-flop synchronizer for every channel input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {ch.bus_out, ch.bus_out_parity, ch.operational_out, ch.select_out,
                  ch.hold_out, ch.address_out, ch.command_out, ch.service_out};
      sync2_q <= sync1_q;
    end
  end

  assign s_bus  = sync2_q[14:7];
  assign s_par  = sync2_q[6];
  assign s_op   = sync2_q[5];
  assign s_sel  = sync2_q[4];
  assign s_hold = sync2_q[3];
  assign s_addr = sync2_q[2];
  assign s_cmd  = sync2_q[1];
  assign s_svc  = sync2_q[0];

  assign sh     = s_sel & s_hold;
  assign bus_ok = ^{s_bus, s_par};

  // Select edge history starts "high" and only tracks once the synchronizer holds
  // real samples, so a select already up at reset release is not taken as a new edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q    <= 2'b00;
      sh_prev_q <= 1'b1;
    end else begin
      warm_q    <= {warm_q[0], 1'b1};
      if (warm_q[1]) sh_prev_q <= sh;
    end
  end

  assign sh_rise = warm_q[1] & sh & ~sh_prev_q;
  assign tmo_c   = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  // Dwell counter, cleared on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         cnt_q <= '0;
    else if (next_state != state_q || state_q == IDLE) cnt_q <= '0;
    else                                               cnt_q <= cnt_q + CNT_W'(1);
  end

  always_comb begin
    next_state = state_q;
    if (!s_op || tmo_c) begin
      next_state = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (sh_rise) next_state = (s_addr && s_bus == CU_ADDRESS && bus_ok)
                                              ? SELECTED : PROPAGATE;
        PROPAGATE:  if (!sh)             next_state = IDLE;
        SELECTED:   if (!s_addr)         next_state = ADDR_IN;
        ADDR_IN:    if (s_cmd)           next_state = CMD_WAIT;
        CMD_WAIT:   if (!s_cmd)          next_state = STATUS_IN;
        STATUS_IN:  if (s_cmd || s_svc)  next_state = STATUS_END;
        STATUS_END: if (!s_svc && !s_cmd) next_state = DISCONNECT;
        DISCONNECT: if (!sh)             next_state = IDLE;
        default:                         next_state = IDLE;
      endcase
    end
  end

  // Next values of all registered outputs, decoded from the state being entered
  always_comb begin
    op_d   = 1'b0;
    sel_d  = 1'b0;
    addr_d = 1'b0;
    stat_d = 1'b0;
    bus_d  = 8'h00;
    cv_d   = 1'b0;
    cb_d   = cmd_byte;
    pe_d   = cmd_parity_error;
    acc_d  = 1'b0;
    stk_d  = 1'b0;
    tmo_d  = s_op & tmo_c;
    case (next_state)
      PROPAGATE: sel_d = sh;
      SELECTED, CMD_WAIT, STATUS_END, DISCONNECT: op_d = 1'b1;
      ADDR_IN: begin
        op_d   = 1'b1;
        addr_d = 1'b1;
        bus_d  = CU_ADDRESS;
      end
      STATUS_IN: begin
        op_d   = 1'b1;
        stat_d = 1'b1;
        bus_d  = (state_q == CMD_WAIT) ? status_byte : ch.bus_in;
      end
      default: ;
    endcase
    par_d = ~^bus_d;
    if (state_q == ADDR_IN && next_state == CMD_WAIT) begin
      cv_d = 1'b1;
      cb_d = s_bus;
      pe_d = ~bus_ok;
    end
    // Command wins over service when both are seen together
    if (state_q == STATUS_IN && next_state == STATUS_END) begin
      stk_d = s_cmd;
      acc_d = ~s_cmd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch.bus_in         <= 8'h00;
      ch.bus_in_parity  <= 1'b1;
      ch.operational_in <= 1'b0;
      ch.select_in      <= 1'b0;
      ch.address_in     <= 1'b0;
      ch.status_in      <= 1'b0;
      cmd_valid         <= 1'b0;
      cmd_byte          <= 8'h00;
      cmd_parity_error  <= 1'b0;
      status_accepted   <= 1'b0;
      status_stacked    <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      ch.bus_in         <= bus_d;
      ch.bus_in_parity  <= par_d;
      ch.operational_in <= op_d;
      ch.select_in      <= sel_d;
      ch.address_in     <= addr_d;
      ch.status_in      <= stat_d;
      cmd_valid         <= cv_d;
      cmd_byte          <= cb_d;
      cmd_parity_error  <= pe_d;
      status_accepted   <= acc_d;
      status_stacked    <= stk_d;
      timeout           <= tmo_d;
    end
  end

  assign ch.request_in = 1'b0;
endmodule
